posterior_decoder: RTL and testbench

//  Receiving end of the per-class inference columns. Collects each column's output,

---
 rtl/posterior_decoder_if.sv | 32 +++
 rtl/posterior_decoder.sv | 146 ++++++++++++++
 tb/tb_posterior_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/posterior_decoder_if.sv
// Decoder handshake and column bus: start/busy/done transaction plus
// per-class stochastic bits and log-domain sums in, winner/score/tie out.
interface posterior_decoder_if #(
  parameter int M       = 8,
  parameter int N_CLASS = 4,
  parameter int CNT_W   = 10
);
  localparam int SW = (CNT_W > M) ? CNT_W : M;
  localparam int IW = $clog2(N_CLASS);

  logic                          start;
  logic                          stoch_log;
  logic [CNT_W-1:0]              n_cycles;
  logic                          bit_valid;
  logic [N_CLASS-1:0]            bit_in;
  logic                          data_valid;
  logic [N_CLASS-1:0][M-1:0]     data_in;
  logic                          busy;
  logic                          done;
  logic [IW-1:0]                 winner;
  logic [SW-1:0]                 score;
  logic                          tie;

  modport master (
    output start, stoch_log, n_cycles, bit_valid, bit_in, data_valid, data_in,
    input  busy, done, winner, score, tie
  );
  modport slave (
    input  start, stoch_log, n_cycles, bit_valid, bit_in, data_valid, data_in,
    output busy, done, winner, score, tie
  );
endinterface

// File: rtl/posterior_decoder.sv
// Collects per-class column outputs (stochastic bit counts or log sums) and
// decodes the winning class with a sequential argmax, one class per cycle.
module posterior_lane #(
  parameter int M     = 8,
  parameter int CNT_W = 10,
  parameter int SW    = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          bit_i,
  input  logic          ld_i,
  input  logic [M-1:0]  data_i,
  output logic [SW-1:0] score_o
);
  localparam logic [SW-1:0] SAT = SW'({CNT_W{1'b1}});

  logic [SW-1:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (clr_i)                                  score_d = '0;
    else if (ld_i)                              score_d = SW'(data_i);
    else if (inc_i && bit_i && score_q != SAT)  score_d = score_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score_o = score_q;
endmodule

module posterior_decoder #(
  parameter int M       = 8,
  parameter int N_CLASS = 4,
  parameter int CNT_W   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  posterior_decoder_if.slave dec_if
);
  localparam int SW = (CNT_W > M) ? CNT_W : M;
  localparam int IW = $clog2(N_CLASS);

  typedef enum logic [1:0] {IDLE, RUN, DECIDE, DONE} state_t;

  state_t                     state_q;
  logic                       mode_q;
  logic [CNT_W-1:0]           rem_q;
  logic [IW-1:0]              idx_q, best_idx_q, winner_q;
  logic [SW-1:0]              best_q, score_q;
  logic                       tie_q, tie_out_q, busy_q, done_q;
  logic [N_CLASS-1:0][SW-1:0] lane_score;
  logic [SW-1:0]              cur;
  logic                       accept, inc, ld;

  // done_q is high while state is already back in IDLE; a start in that cycle must be dropped
  assign accept = (state_q == IDLE) && dec_if.start && !done_q;
  assign inc    = (state_q == RUN) && !mode_q && dec_if.bit_valid;
  assign ld     = (state_q == RUN) &&  mode_q && dec_if.data_valid;
  assign cur    = lane_score[idx_q];

  for (genvar g = 0; g < N_CLASS; g++) begin : g_lane
    posterior_lane #(.M(M), .CNT_W(CNT_W), .SW(SW)) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (accept),
      .inc_i   (inc),
      .bit_i   (dec_if.bit_in[g]),
      .ld_i    (ld),
      .data_i  (dec_if.data_in[g]),
      .score_o (lane_score[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      rem_q      <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_q     <= '0;
      tie_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      winner_q   <= '0;
      score_q    <= '0;
      tie_out_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          mode_q    <= dec_if.stoch_log;
          rem_q     <= dec_if.n_cycles;
          idx_q     <= '0;
          busy_q    <= 1'b1;
          winner_q  <= '0;
          score_q   <= '0;
          tie_out_q <= 1'b0;
          state_q   <= (!dec_if.stoch_log && dec_if.n_cycles == '0) ? DECIDE : RUN;
        end
        RUN: begin
          if (!mode_q) begin
            if (dec_if.bit_valid) begin
              rem_q <= rem_q - 1'b1;
              if (rem_q == CNT_W'(1)) state_q <= DECIDE;
            end
          end else if (dec_if.data_valid) begin
            state_q <= DECIDE;
          end
        end
        DECIDE: begin
          // ties keep the lower index, so only strictly greater replaces
          if (idx_q == '0 || cur > best_q) begin
            best_q     <= cur;
            best_idx_q <= idx_q;
            tie_q      <= 1'b0;
          end else if (cur == best_q) begin
            tie_q <= 1'b1;
          end
          if (idx_q == IW'(N_CLASS - 1)) state_q <= DONE;
          else                           idx_q   <= idx_q + 1'b1;
        end
        DONE: begin
          winner_q  <= best_idx_q;
          score_q   <= best_q;
          tie_out_q <= tie_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dec_if.busy   = busy_q;
  assign dec_if.done   = done_q;
  assign dec_if.winner = winner_q;
  assign dec_if.score  = score_q;
  assign dec_if.tie    = tie_out_q;
endmodule

// File: tb/tb_posterior_decoder.sv
// Randomized bench for posterior_decoder against a count/argmax reference model.
module tb_posterior_decoder;
  localparam int M  = 8;
  localparam int NC = 4;
  localparam int CW = 4;
  localparam int SATV = (1 << CW) - 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  posterior_decoder_if #(.M(M), .N_CLASS(NC), .CNT_W(CW)) dif ();

  posterior_decoder #(.M(M), .N_CLASS(NC), .CNT_W(CW)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .dec_if (dif)
  );

  int nchk = 0;
  int nfail = 0;
  int mdl [NC];
  int exp_w, exp_s, exp_t;

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_done(output int lat);
    int k;
    bit seen;
    k = 0;
    seen = 0;
    while (!seen && k < 64) begin
      step();
      k++;
      if (dif.done === 1'b1) seen = 1;
    end
    lat = seen ? k : -1;
  endtask

  // argmax over the model scores: lowest index of the max, tie if max repeats
  task automatic model_result();
    int best, nbest;
    best = -1;
    nbest = 0;
    exp_w = 0;
    for (int i = 0; i < NC; i++) if (mdl[i] > best) begin best = mdl[i]; exp_w = i; end
    for (int i = 0; i < NC; i++) if (mdl[i] == best) nbest++;
    exp_s = best;
    exp_t = (nbest > 1) ? 1 : 0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_winner"}, int'(dif.winner), exp_w);
    chk({tag, "_score"},  int'(dif.score),  exp_s);
    chk({tag, "_tie"},    int'(dif.tie),    exp_t);
    chk({tag, "_busy"},   int'(dif.busy),   0);
  endtask

  task automatic settle();
    step();
    chk("done_pulse", int'(dif.done), 0);
    chk("hold_w", int'(dif.winner), exp_w);
    chk("hold_s", int'(dif.score), exp_s);
  endtask

  task automatic start_cleared(input string tag);
    chk({tag, "_acc_busy"}, int'(dif.busy), 1);
    chk({tag, "_acc_clr"}, int'({dif.winner, dif.score, dif.tie}), 0);
  endtask

  // vmode: 0 always valid, 1 toggling starting valid, 2 random with bounded stalls
  task automatic run_stoch(input int n, input int vmode, input logic [NC-1:0] pat, input bit rbits);
    int got, stalls, lat;
    logic v, vprev;
    logic [NC-1:0] b;
    dif.start = 1'b1; dif.stoch_log = 1'b0; dif.n_cycles = CW'(n);
    dif.bit_valid = 1'b0; dif.data_valid = 1'b0;
    step();
    dif.start = 1'b0;
    start_cleared("stoch");
    for (int i = 0; i < NC; i++) mdl[i] = 0;
    got = 0; stalls = 0; vprev = 1'b0;
    while (got < n) begin
      if (vmode == 0)      v = 1'b1;
      else if (vmode == 1) v = ~vprev;
      else                 v = ($urandom_range(3, 0) != 0) || stalls >= 3;
      vprev = v;
      b = rbits ? NC'($urandom) : pat;
      dif.bit_valid = v; dif.bit_in = b; dif.data_valid = 1'($urandom);
      step();
      chk("run_busy", int'(dif.busy), 1);
      if (v) begin
        for (int i = 0; i < NC; i++) if (b[i] && mdl[i] < SATV) mdl[i]++;
        got++; stalls = 0;
      end else stalls++;
    end
    dif.bit_valid = 1'b0; dif.data_valid = 1'b0;
    wait_done(lat);
    chk("stoch_lat", lat, NC + 1);
    model_result();
    check_out("stoch");
  endtask

  task automatic run_log(input logic [NC-1:0][M-1:0] d, input int idle, input bit restart);
    int lat;
    dif.start = 1'b1; dif.stoch_log = 1'b1; dif.n_cycles = CW'($urandom);
    dif.bit_valid = 1'b1; dif.bit_in = NC'($urandom); dif.data_valid = 1'b0;
    step();
    dif.start = 1'b0;
    start_cleared("log");
    for (int k = 0; k < idle; k++) begin
      dif.start = restart && (k == 0);
      dif.stoch_log = 1'($urandom);
      dif.data_valid = 1'b0; dif.data_in = $urandom;
      dif.bit_valid = 1'($urandom); dif.bit_in = NC'($urandom);
      step();
      chk("log_wait_busy", int'(dif.busy), 1);
    end
    dif.start = 1'b0;
    dif.data_valid = 1'b1; dif.data_in = d;
    step();
    dif.data_valid = 1'b0; dif.data_in = $urandom;
    wait_done(lat);
    chk("log_lat", lat, NC + 1);
    for (int i = 0; i < NC; i++) mdl[i] = int'(d[i]);
    model_result();
    check_out("log");
  endtask

  initial begin
    int lat;
    logic [NC-1:0][M-1:0] d;
    dif.start = 1'b0; dif.stoch_log = 1'b0; dif.n_cycles = '0;
    dif.bit_valid = 1'b0; dif.bit_in = '0; dif.data_valid = 1'b0; dif.data_in = '0;
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    chk("rst_busy", int'(dif.busy), 0);
    chk("rst_done", int'(dif.done), 0);
    chk("rst_out", int'({dif.winner, dif.score, dif.tie}), 0);

    run_stoch(8, 0, 4'b0101, 0);             settle();
    run_stoch(4, 1, 4'b1000, 0);             settle();
    run_stoch(15, 0, 4'b0100, 0);            settle();
    run_stoch(0, 0, 4'b0000, 0);             settle();

    d = {8'd20, 8'd200, 8'd199, 8'd5};
    run_log(d, 3, 1);                         settle();
    step(); chk("log_restart_dropped", int'(dif.busy), 0);

    // abort a run with reset
    dif.start = 1'b1; dif.stoch_log = 1'b0; dif.n_cycles = CW'(10);
    dif.bit_valid = 1'b1; dif.bit_in = 4'b1111;
    step();
    dif.start = 1'b0;
    step(); step(); step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; dif.bit_valid = 1'b0;
    chk("abort_busy", int'(dif.busy), 0);
    chk("abort_out", int'({dif.winner, dif.score, dif.tie, dif.done}), 0);
    for (int k = 0; k < NC + 12; k++) begin
      step();
      chk("abort_nodone", int'(dif.done), 0);
    end
    run_stoch(2, 0, 4'b0010, 0);

    // start coincident with done is dropped, start one cycle later is taken
    dif.start = 1'b1; dif.stoch_log = 1'b0; dif.n_cycles = CW'(1);
    dif.bit_valid = 1'b1; dif.bit_in = 4'b0001;
    step();
    chk("done_start_ign", int'(dif.busy), 0);
    chk("done_start_hold", int'(dif.winner), exp_w);
    step();
    dif.start = 1'b0;
    chk("next_start_acc", int'(dif.busy), 1);
    step();
    dif.bit_valid = 1'b0;
    wait_done(lat);
    chk("t6_lat", lat, NC + 1);
    for (int i = 0; i < NC; i++) mdl[i] = (i == 0) ? 1 : 0;
    model_result();
    check_out("t6");
    settle();

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(1, 0) == 0) begin
        run_stoch(int'($urandom_range(SATV, 0)), 2, '0, 1);
      end else begin
        for (int i = 0; i < NC; i++)
          d[i] = ($urandom_range(1, 0) == 0) ? M'($urandom_range(3, 0)) : M'($urandom);
        run_log(d, int'($urandom_range(4, 0)), 1'($urandom));
      end
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
